sprite_update_scheduler: RTL and testbench

- Buffers host sprite-register writes (position, sprite number, attribute bits) from the Avalon slave port in a small FIFO.
- Replays the buffered writes to the display register file only during vertical blanking, so sprites never tear mid-frame.
- Sits between the Avalon bus and the display engine's register-write inputs.
- Uses the VGA counters' hcount/vcount for frame timing.
- Also provides a status/control register and a once-per-frame tick for software pacing.

---
 rtl/sprite_update_scheduler.sv | 143 ++++++++++++++
 tb/tb_sprite_update_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_update_scheduler.sv
// Queues host sprite-register writes and replays them to the display registers only during vblank.
// Also provides a status/control register, a sticky overflow flag and a once-per-frame tick.
module sprite_update_scheduler #(
  parameter int         DEPTH       = 16,
  parameter int         LVL_W       = 5,
  parameter int         VACTIVE     = 480,
  parameter logic [3:0] STATUS_ADDR = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        disp_we,
  output logic [3:0]  disp_addr,
  output logic [7:0]  disp_data,
  output logic        frame_tick,
  output logic        overflow
);

  localparam int PTR_W = LVL_W - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state;
  logic [11:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;

  logic host_wr;
  logic push_req;
  logic stat_wr;
  logic flush;
  logic ovf_clr;
  logic vblank_start;
  logic in_vblank;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;
  logic [7:0] status_word;

  assign host_wr      = chipselect && write;
  assign push_req     = host_wr && (address != STATUS_ADDR);
  assign stat_wr      = host_wr && (address == STATUS_ADDR);
  assign flush        = stat_wr && writedata[0];
  assign ovf_clr      = stat_wr && writedata[7];
  assign vblank_start = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
  assign in_vblank    = (vcount >= 10'(VACTIVE));
  assign fifo_empty   = (level == '0);
  assign fifo_full    = (level == LVL_W'(DEPTH));

  // A flush wins over the pop; a frame wrap stops draining with the head left in place.
  assign pop  = (state == DRAIN) && !flush && in_vblank && !fifo_empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push = push_req && (!fifo_full || pop);
  assign drop = push_req && !push;

  assign status_word = {overflow, (state == DRAIN), 1'b0, 5'(level)};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {address, writedata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      disp_we    <= 1'b0;
      disp_addr  <= 4'h0;
      disp_data  <= 8'h00;
      frame_tick <= 1'b0;
      overflow   <= 1'b0;
      readdata   <= 8'h00;
    end else begin
      frame_tick <= vblank_start;
      disp_we    <= pop;
      if (pop) begin
        {disp_addr, disp_data} <= mem[rd_ptr];
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      if (chipselect && read) begin
        readdata <= (address == STATUS_ADDR) ? status_word : 8'h00;
      end

      case (state)
        IDLE: begin
          if (vblank_start) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush || !in_vblank || fifo_empty) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_update_scheduler.sv
// Bench for sprite_update_scheduler: queue-based reference model checked every cycle, plus directed literal checks.
module tb_sprite_update_scheduler;

  localparam int         DEPTH   = 16;
  localparam int         VACTIVE = 480;
  localparam logic [3:0] SA      = 4'hF;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [3:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        disp_we;
  logic [3:0]  disp_addr;
  logic [7:0]  disp_data;
  logic        frame_tick;
  logic        overflow;

  sprite_update_scheduler #(
    .DEPTH(DEPTH), .LVL_W(5), .VACTIVE(VACTIVE), .STATUS_ADDR(SA)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .hcount(hcount), .vcount(vcount), .disp_we(disp_we), .disp_addr(disp_addr),
    .disp_data(disp_data), .frame_tick(frame_tick), .overflow(overflow)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Reference model: a queue of {addr,data} plus the expected registered outputs.
  typedef logic [11:0] ent_t;
  ent_t       mq[$];
  bit         m_ovf   = 0;
  bit         m_drain = 0;
  bit         e_we    = 0;
  bit         e_tick  = 0;
  logic [3:0] e_addr  = 4'h0;
  logic [7:0] e_data  = 8'h00;
  logic [7:0] e_rd    = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_drain = 0; e_we = 0; e_tick = 0;
      e_addr = 4'h0; e_data = 8'h00; e_rd = 8'h00;
    end else begin : model_step
      bit   vb, preq, swr, flsh, pop, dropped;
      int   size0;
      ent_t it;
      vb      = (hcount == 0) && (vcount == VACTIVE);
      preq    = chipselect && write && (address != SA);
      swr     = chipselect && write && (address == SA);
      flsh    = swr && writedata[0];
      size0   = mq.size();
      pop     = m_drain && !flsh && (vcount >= VACTIVE) && (size0 != 0);
      dropped = 0;
      if (chipselect && read)
        e_rd = (address == SA) ? {m_ovf, m_drain, 1'b0, 5'(size0)} : 8'h00;
      e_tick = vb;
      e_we   = pop;
      if (pop) begin
        it = mq.pop_front();
        e_addr = it[11:8];
        e_data = it[7:0];
      end
      if (flsh) mq.delete();
      if (preq) begin
        if (mq.size() < DEPTH) mq.push_back({address, writedata});
        else dropped = 1;
      end
      if (swr && writedata[7]) m_ovf = 0;
      if (dropped) m_ovf = 1;
      if (!m_drain) m_drain = vb;
      else if (flsh || (vcount < VACTIVE) || (size0 == 0)) m_drain = 0;
    end
  end

  bit   chk_en = 0;
  int   cyc = 0;
  ent_t cap[$];
  int   cap_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs{we,addr,data,tick,ovf,rd}",
            {9'd0, disp_we, disp_addr, disp_data, frame_tick, overflow, readdata},
            {9'd0, e_we, e_addr, e_data, e_tick, m_ovf, e_rd});
      if (disp_we) begin
        cap.push_back({disp_addr, disp_data});
        cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write = 0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    chipselect = 1; read = 1; address = a;
    @(negedge clk);
    chipselect = 0; read = 0;
    d = readdata;
  endtask

  task automatic vblank();
    hcount = 0; vcount = 10'(VACTIVE);
    @(negedge clk);
    hcount = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    ent_t       exp_list[$];
    clk = 0; reset = 0; chipselect = 0; write = 0; read = 0;
    address = 0; writedata = 0; hcount = 5; vcount = 100;
    #1 reset = 1;
    chk_en = 1;
    idle(3);
    reset = 0;
    idle(1);
    check("reset_outputs", {disp_we, frame_tick, overflow, readdata, disp_addr, disp_data}, 0);
    rd(SA, d);
    check("reset_status", d, 8'h00);

    // Three writes during active video, replayed in order at vblank.
    cap.delete(); cap_cyc.delete();
    wr(4'h0, 8'h20); wr(4'h1, 8'h30); wr(4'h2, 8'h01);
    idle(2);
    check("active_no_we", cap.size(), 0);
    rd(SA, d);
    check("status_level3", d, 8'h03);
    vblank();
    check("frame_tick", frame_tick, 1'b1);
    idle(6);
    vcount = 100; idle(2);
    check("basic_count", cap.size(), 3);
    if (cap.size() == 3) begin
      check("basic_0", cap[0], 12'h020);
      check("basic_1", cap[1], 12'h130);
      check("basic_2", cap[2], 12'h201);
      check("basic_consecutive", cap_cyc[2] - cap_cyc[0], 2);
    end

    // 17 writes: the last is dropped and overflow sticks until cleared.
    cap.delete(); exp_list.delete();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_list.push_back({4'(i % 15), 8'(i * 7 + 3)});
      wr(4'(i % 15), 8'(i * 7 + 3));
    end
    check("overflow_set", overflow, 1'b1);
    rd(SA, d);
    check("status_full_ovf", d, 8'h90);
    wr(SA, 8'h80);
    check("overflow_clear", overflow, 1'b0);
    rd(SA, d);
    check("status_full", d, 8'h10);
    vblank(); idle(20);
    vcount = 100; idle(2);
    check("drain16_count", cap.size(), 16);
    for (int i = 0; i < 16 && i < cap.size(); i++) check("drain16_order", cap[i], exp_list[i]);

    // Full FIFO: push in the same cycle as the first pop is accepted.
    cap.delete();
    for (int i = 0; i < 16; i++) wr(4'(i % 15), 8'(i));
    vblank();
    wr(4'h7, 8'hA5);
    check("full_pushpop_ovf", overflow, 1'b0);
    rd(SA, d);
    check("full_pushpop_level", d, 8'h50);
    idle(20);
    vcount = 100; idle(2);
    check("full_pushpop_count", cap.size(), 17);
    if (cap.size() == 17) check("full_pushpop_last", cap[16], 12'h7A5);

    // Frame wrap after two pops: the rest waits for the next vblank.
    cap.delete(); exp_list.delete();
    for (int i = 0; i < 4; i++) begin
      exp_list.push_back({4'(i + 3), 8'(8'h40 + i)});
      wr(4'(i + 3), 8'(8'h40 + i));
    end
    vblank(); idle(2);
    vcount = 0; idle(4);
    check("wrap_first_frame", cap.size(), 2);
    vcount = 100; idle(3);
    vblank(); idle(6);
    vcount = 100; idle(2);
    check("wrap_total", cap.size(), 4);
    for (int i = 0; i < 4 && i < cap.size(); i++) check("wrap_order", cap[i], exp_list[i]);

    // Flush with five entries left mid-drain.
    cap.delete();
    for (int i = 0; i < 7; i++) wr(4'(i), 8'(8'h90 + i));
    vblank(); idle(2);
    wr(SA, 8'h01);
    idle(6);
    check("flush_count", cap.size(), 2);
    rd(SA, d);
    check("flush_status", d, 8'h00);
    vcount = 100; idle(2);

    // Reset during drain loses everything still queued.
    cap.delete();
    for (int i = 0; i < 6; i++) wr(4'(i), 8'(8'hC0 + i));
    vblank(); idle(1);
    #2 reset = 1;
    idle(2);
    reset = 0;
    idle(8);
    check("reset_mid_drain_count", cap.size(), 1);
    rd(SA, d);
    check("reset_mid_drain_status", d, 8'h00);
    vcount = 100; idle(2);

    // Randomised traffic over a compressed frame, checked every cycle by the model.
    cap.delete();
    begin
      int h, v, r;
      h = 0; v = 470;
      for (int c = 0; c < 4000; c++) begin
        hcount = 11'(h); vcount = 10'(v);
        chipselect = 0; write = 0; read = 0;
        r = $urandom_range(0, 99);
        if (r < 45) begin
          chipselect = 1; write = 1;
          address = 4'($urandom_range(0, 14)); writedata = 8'($urandom);
        end else if (r < 48) begin
          chipselect = 1; write = 1; address = SA;
          writedata = 8'($urandom) & 8'hFE;
          if ($urandom_range(0, 3) == 0) writedata[0] = 1'b1;
        end else if (r < 65) begin
          chipselect = 1; read = 1;
          address = ($urandom_range(0, 1) == 1) ? SA : 4'($urandom_range(0, 14));
        end
        @(negedge clk);
        h++;
        if (h == 4) begin
          h = 0; v++;
          if (v == 490) v = 0;
          else if (v == 1) v = 470;
        end
      end
      chipselect = 0; write = 0; read = 0;
    end
    idle(2);
    check("random_activity", cap.size() > 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
